half_vector_gather: RTL and testbench

- Serial-to-parallel front end for the half-precision vector reduction path.
- Accepts a stream of IEEE-754 binary16 elements, one per cycle, and assembles them into a WIDTH-lane vector.
- Short vectors (terminated early by in_last) are zero-padded.
- Presents the vector with a single-cycle valid pulse, matching the in_valid/vector_a inputs of the vector sum tree, which has no backpressure.

---
 rtl/half_vector_gather.sv | 102 ++++++++++
 tb/tb_half_vector_gather.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/half_vector_gather.sv
// Serial-to-parallel gather of binary16 elements into a WIDTH-lane vector.
// Short vectors are padded with PAD; each completed vector is announced by a one-cycle out_valid.
module half_vector_gather #(
    parameter int          WIDTH = 10,
    parameter logic [15:0] PAD   = 16'h0000,
    localparam int         IDX_W = $clog2(WIDTH),
    localparam int         CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic [15:0]      out_vector [WIDTH],
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {
        EMPTY   = 1'b0,
        FILLING = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             complete;

    // The last lane always closes the vector, with or without in_last.
    assign complete = in_valid && (in_last || (idx_reg == LAST_IDX));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= EMPTY;
            idx_reg   <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state_reg)
                EMPTY: begin
                    if (in_valid) begin
                        if (complete) begin
                            out_valid <= 1'b1;
                            out_count <= CNT_W'(1);
                        end else begin
                            idx_reg   <= IDX_W'(1);
                            state_reg <= FILLING;
                        end
                    end
                end
                FILLING: begin
                    if (in_valid) begin
                        if (complete) begin
                            out_valid <= 1'b1;
                            out_count <= CNT_W'(idx_reg) + CNT_W'(1);
                            idx_reg   <= '0;
                            state_reg <= EMPTY;
                        end else begin
                            idx_reg <= idx_reg + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    idx_reg   <= '0;
                    state_reg <= EMPTY;
                end
            endcase
        end
    end

    // Each lane owns one fill register and one output register.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
        logic [15:0] fill_reg;
        logic [15:0] out_reg;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                fill_reg <= PAD;
                out_reg  <= PAD;
            end else if (in_valid) begin
                if (complete) begin
                    // The completing element bypasses the fill buffer straight into its lane.
                    fill_reg <= PAD;
                    if (gi < int'(idx_reg)) begin
                        out_reg <= fill_reg;
                    end else if (gi == int'(idx_reg)) begin
                        out_reg <= in_data;
                    end else begin
                        out_reg <= PAD;
                    end
                end else if (gi == int'(idx_reg)) begin
                    fill_reg <= in_data;
                end
            end
        end

        assign out_vector[gi] = out_reg;
    end

endmodule

// File: tb/tb_half_vector_gather.sv
// Randomised and directed scoreboard bench for half_vector_gather at WIDTH=4.
// A queue-based reference model predicts each vector and the cycle it must appear in.
module tb_half_vector_gather;

    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic [15:0] out_vector [W];
    logic [2:0]  out_count;

    half_vector_gather #(.WIDTH(W), .PAD(16'h0000)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_vector (out_vector),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0][15:0] v;
        logic [2:0]         cnt;
        int                 due;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] pend[$];
    exp_t        last_exp = '0;
    int          errors = 0;
    int          checks = 0;
    int          pulses = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string name, input exp_t e);
        for (int i = 0; i < W; i++) begin
            check($sformatf("%s_lane%0d", name, i), 64'(out_vector[i]), 64'(e.v[i]));
        end
        check($sformatf("%s_count", name), 64'(out_count), 64'(e.cnt));
    endtask

    // Reference: collect accepted elements; a vector closes on in_last or when W are held.
    function automatic void model_accept(input logic [15:0] d, input logic l);
        exp_t e;
        pend.push_back(d);
        if (l || pend.size() == W) begin
            e     = '0;
            e.cnt = 3'(pend.size());
            for (int i = 0; i < W; i++) begin
                e.v[i] = (i < pend.size()) ? pend[i] : 16'h0000;
            end
            e.due = cyc + 1;
            sb.push_back(e);
            pend.delete();
        end
    endfunction

    // Monitor: every pulse must match the oldest predicted vector, in the predicted cycle.
    always @(negedge clk) begin
        if (rstn && out_valid) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                check("spurious_pulse", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                last_exp = e;
                check("pulse_cycle", 64'(cyc), 64'(e.due));
                check_outputs("vec", e);
                $display("txn %0d: cnt=%0d lanes=%h %h %h %h", pulses, out_count,
                         out_vector[0], out_vector[1], out_vector[2], out_vector[3]);
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        model_accept(d, l);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n, input logic last_noise);
        in_valid = 1'b0;
        in_last  = last_noise;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        in_last = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_valid", 64'(out_valid), 64'(0));
        check_outputs("rst", last_exp);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(3, 1'b0);
        check("idle_valid", 64'(out_valid), 64'(0));
        check_outputs("idle", last_exp);

        // Full vector, auto-complete
        send(16'h3C00, 1'b0);
        send(16'h4000, 1'b0);
        send(16'h4200, 1'b0);
        send(16'h4400, 1'b0);
        idle(2, 1'b0);

        // Short vectors, contiguous and with gaps
        send(16'h3C00, 1'b0);
        send(16'hBC00, 1'b1);
        idle(2, 1'b0);
        send(16'h3C00, 1'b0);
        idle(3, 1'b1);
        send(16'hBC00, 1'b1);
        idle(2, 1'b0);

        // Back-to-back single-element vectors, special values
        send(16'h7C00, 1'b1);
        send(16'hFE00, 1'b1);
        send(16'h8000, 1'b1);
        idle(2, 1'b0);

        // Hold: outputs stable, in_last without in_valid ignored
        in_last = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'(0));
            check_outputs("hold", last_exp);
        end
        in_last = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-fill discards the partial vector
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        rstn = 1'b0;
        pend.delete();
        last_exp = '0;
        #3;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check_outputs("midrst", last_exp);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1, 1'b0);
        send(16'h4800, 1'b0);
        send(16'h4900, 1'b0);
        send(16'h4A00, 1'b0);
        send(16'h4B00, 1'b0);
        idle(2, 1'b0);

        // Randomised traffic with gaps and early terminations
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                send(16'($urandom), $urandom_range(0, 4) == 0);
            end else begin
                idle(1, 1'($urandom_range(0, 1)));
            end
        end
        idle(3, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
